bf_mem_arbiter: RTL and testbench
=================================

BF_MEM_ARBITER -- requirements
Module: bf_mem_arbiter

Interface
REQ-001 SHALL provide clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL provide r0_req, r0_we  in  1 each  requester 0 (program loader) access request and write enable.
REQ-004 SHALL provide r0_lock  in  1  requester 0 asks to keep ownership after the current grant.
REQ-005 SHALL provide r0_addr, r0_wdata  in  8 each  requester 0 address and write data.
REQ-006 SHALL provide r0_gnt, r0_rvalid  out  1 each  requester 0 access accepted; read data valid.
REQ-007 SHALL provide r0_rdata  out  8  requester 0 read data.
REQ-008 SHALL provide r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata with widths and meanings identical to requester 0, for requester 1 (interpreter core).
REQ-009 SHALL provide m_en, m_we  out  1 each  memory port enable and write enable.
REQ-010 SHALL provide m_addr, m_wdata  out  8 each  memory address and write data.
REQ-011 SHALL provide m_rdata  in  8  memory read data, valid one cycle after a read with m_en=1.
REQ-012 SHALL provide lock_err  out  1  one-cycle pulse on forced lock release.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt is combinational from req, lock state and priority state.
REQ-014 SHALL drive m_en=1 and m_we/m_addr/m_wdata from the granted requester in the grant cycle; m_en=0 and m_we=0 when no grant.
REQ-015 SHALL keep requests pending until granted; requesters hold req/we/addr/wdata stable until gnt.
REQ-016 SHALL assert rX_rvalid exactly one cycle after a granted read (we=0) with rX_rdata=m_rdata; rvalid SHALL stay 0 after writes.
REQ-017 SHALL hold rX_rdata at the last returned value while rX_rvalid=0.
REQ-018 SHALL implement states IDLE, OWN0, OWN1; IDLE->OWNx when rx is granted with rx_lock=1.
REQ-019 In OWNx SHALL grant only requester x; the other requester SHALL receive no grant.
REQ-020 OWNx->IDLE when x is granted with rx_lock=0, or when rx_req=0 and rx_lock=0 in the same cycle.
REQ-021 SHALL count cycles in OWNx with a 4-bit counter cleared on each OWNx grant; on reaching 15 SHALL force IDLE and pulse lock_err for one cycle.
REQ-022 SHALL, in IDLE with a single request, grant that requester in the same cycle (zero added latency).
REQ-023 SHALL, in IDLE with simultaneous requests, resolve per the priority rule of REQ-027/REQ-028.
REQ-024 SHALL update the last-granted pointer on every grant, including grants made in OWNx.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state IDLE, last-granted pointer to 1, lock counter 0, r0_rvalid=r1_rvalid=0, r0_rdata=r1_rdata=0, lock_err=0.
REQ-026 SHALL, while rst=1, hold r0_gnt=r1_gnt=m_en=m_we=0, drop any read response pending from the previous cycle, and release any lock immediately.

Configuration
REQ-027 With BF_ARB_RR_EN defined, SHALL grant simultaneous IDLE requests round-robin to the requester not granted last (requester 0 first after reset).
REQ-028 Without BF_ARB_RR_EN, SHALL always grant requester 0 on simultaneous IDLE requests; the last-granted pointer SHALL be kept but unused.

Verification
REQ-029 SHALL cover: r0 write addr 8'h10 data 8'h2B, then r1 read 8'h10 -> r1_gnt same cycle, r1_rvalid next cycle, r1_rdata=8'h2B.
REQ-030 SHALL cover: r0_req and r1_req both high for 4 cycles with BF_ARB_RR_EN -> grants r0,r1,r0,r1; without the macro -> r0 on all 4.
REQ-031 SHALL cover: r1 read 8'h05 with lock=1, then write 8'h05 lock=0 while r0_req held high -> r0_gnt=0 until the r1 write is granted, r0 granted the following cycle.
REQ-032 SHALL cover: r1 granted with lock=1 then r1_req=0, r1_lock=1 for 15 cycles -> lock_err pulses once, state IDLE, pending r0_req granted the next cycle.
REQ-033 SHALL cover: rst=1 in the cycle after a granted r0 read -> r0_rvalid=0, no grants, IDLE; after rst=0, simultaneous requests -> r0 granted first.

Source files
------------

// File: rtl/bf_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// bf_mem_arbiter_if
//
// Purpose: bundles the two requester ports and the single-port memory bus
// around bf_mem_arbiter. Signal prefixes are from the arbiter's point of view:
// i_* flows into the arbiter and o_* flows out of it.
//
// Signals:
//   i_rX_req, i_rX_we, i_rX_lock   requester X request / write enable / lock
//   i_rX_addr, i_rX_wdata          requester X address and write data (8b)
//   o_rX_gnt, o_rX_rvalid          requester X grant / read data valid
//   o_rX_rdata                     requester X read data (8b)
//   o_m_en, o_m_we                 memory enable / write enable
//   o_m_addr, o_m_wdata            memory address / write data (8b)
//   i_m_rdata                      memory read data, one cycle after a read
//   o_lock_err                     one-cycle pulse on forced lock release
//
// Modports:
//   slave  - the arbiter side
//   master - the requesters + memory side (testbench / integration)
// ---------------------------------------------------------------------------
interface bf_mem_arbiter_if;

  // Requester 0 (program loader)
  logic       i_r0_req;
  logic       i_r0_we;
  logic       i_r0_lock;
  logic [7:0] i_r0_addr;
  logic [7:0] i_r0_wdata;
  logic       o_r0_gnt;
  logic       o_r0_rvalid;
  logic [7:0] o_r0_rdata;

  // Requester 1 (interpreter core)
  logic       i_r1_req;
  logic       i_r1_we;
  logic       i_r1_lock;
  logic [7:0] i_r1_addr;
  logic [7:0] i_r1_wdata;
  logic       o_r1_gnt;
  logic       o_r1_rvalid;
  logic [7:0] o_r1_rdata;

  // Memory port
  logic       o_m_en;
  logic       o_m_we;
  logic [7:0] o_m_addr;
  logic [7:0] o_m_wdata;
  logic [7:0] i_m_rdata;

  // Status
  logic       o_lock_err;

  modport slave (
    input  i_r0_req, i_r0_we, i_r0_lock, i_r0_addr, i_r0_wdata,
    output o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    input  i_r1_req, i_r1_we, i_r1_lock, i_r1_addr, i_r1_wdata,
    output o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    output o_m_en, o_m_we, o_m_addr, o_m_wdata,
    input  i_m_rdata,
    output o_lock_err
  );

  modport master (
    output i_r0_req, i_r0_we, i_r0_lock, i_r0_addr, i_r0_wdata,
    input  o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    output i_r1_req, i_r1_we, i_r1_lock, i_r1_addr, i_r1_wdata,
    input  o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    input  o_m_en, o_m_we, o_m_addr, o_m_wdata,
    output i_m_rdata,
    input  o_lock_err
  );

endinterface

// File: rtl/bf_mem_arbiter.sv
// ---------------------------------------------------------------------------
// bf_mem_arbiter
//
// Purpose: two-requester arbiter in front of a single-port synchronous memory.
// Requester 0 is the program loader, requester 1 the interpreter core. A
// requester may lock the memory across several accesses; a lock left idle for
// 15 cycles is forcibly released and reported on o_lock_err.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - bf_mem_arbiter_if.slave (requester ports + memory port + lock_err)
//
// Configuration:
//   BF_ARB_RR_EN - when defined, simultaneous requests in IDLE are granted
//                  round-robin (requester 0 first after reset). When undefined,
//                  requester 0 always wins; the last-granted pointer is still
//                  maintained but does not affect arbitration.
// ---------------------------------------------------------------------------
module bf_mem_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  bf_mem_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

  arbState_t  r_state;
  arbState_t  w_nextState;

  // Last-granted requester: 0 or 1. Reset to 1 so requester 0 goes first.
  logic       r_last;
  logic [3:0] r_lockCnt;
  logic [3:0] w_nextCnt;
  logic [3:0] w_cntInc;
  logic       r_lockErr;
  logic       w_forceRel;

  logic       w_gnt0;
  logic       w_gnt1;

  // A granted read is outstanding; the memory answers in the next cycle.
  logic       r_pend0;
  logic       r_pend1;
  logic [7:0] r_hold0;
  logic [7:0] r_hold1;

  assign w_cntInc = r_lockCnt + 4'd1;

  // Grant selection and lock state machine. Grants are purely combinational
  // so a lone request in IDLE is served in the cycle it appears. While reset
  // is high no grant is issued at all, which also releases any lock at once.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_lockCnt;
    w_forceRel  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.i_r0_req && bus.i_r1_req) begin
`ifdef BF_ARB_RR_EN
          if (r_last) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
`else
          w_gnt0 = 1'b1;
`endif
        end else if (bus.i_r0_req) begin
          w_gnt0 = 1'b1;
        end else if (bus.i_r1_req) begin
          w_gnt1 = 1'b1;
        end

        if (w_gnt0 && bus.i_r0_lock) begin
          w_nextState = OWN0;
          w_nextCnt   = 4'd0;
        end else if (w_gnt1 && bus.i_r1_lock) begin
          w_nextState = OWN1;
          w_nextCnt   = 4'd0;
        end
      end

      OWN0: begin
        w_gnt0 = bus.i_r0_req;
        if (bus.i_r0_req) begin
          w_nextCnt = 4'd0;
          if (!bus.i_r0_lock) begin
            w_nextState = IDLE;
          end
        end else if (!bus.i_r0_lock) begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
        end else if (w_cntInc == 4'd15) begin
          // Owner has been idle for 15 cycles while still holding the lock.
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
          w_forceRel  = 1'b1;
        end else begin
          w_nextCnt = w_cntInc;
        end
      end

      OWN1: begin
        w_gnt1 = bus.i_r1_req;
        if (bus.i_r1_req) begin
          w_nextCnt = 4'd0;
          if (!bus.i_r1_lock) begin
            w_nextState = IDLE;
          end
        end else if (!bus.i_r1_lock) begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
        end else if (w_cntInc == 4'd15) begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
          w_forceRel  = 1'b1;
        end else begin
          w_nextCnt = w_cntInc;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase

    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // State, pointer, counter and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_lockCnt <= 4'd0;
      r_lockErr <= 1'b0;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_hold0   <= 8'd0;
      r_hold1   <= 8'd0;
    end else begin
      r_state   <= w_nextState;
      r_lockCnt <= w_nextCnt;
      r_lockErr <= w_forceRel;
      r_last    <= (w_gnt0 || w_gnt1) ? w_gnt1 : r_last;
      r_pend0   <= w_gnt0 && !bus.i_r0_we;
      r_pend1   <= w_gnt1 && !bus.i_r1_we;
      // Remember the returned word so rdata stays put once rvalid drops.
      if (r_pend0) begin
        r_hold0 <= bus.i_m_rdata;
      end
      if (r_pend1) begin
        r_hold1 <= bus.i_m_rdata;
      end
    end
  end

  // Requester responses. A pending read is squashed while reset is high.
  always_comb begin
    bus.o_r0_gnt    = w_gnt0;
    bus.o_r1_gnt    = w_gnt1;
    bus.o_r0_rvalid = r_pend0 && !rst;
    bus.o_r1_rvalid = r_pend1 && !rst;
    bus.o_r0_rdata  = (r_pend0 && !rst) ? bus.i_m_rdata : r_hold0;
    bus.o_r1_rdata  = (r_pend1 && !rst) ? bus.i_m_rdata : r_hold1;
    bus.o_lock_err  = r_lockErr;
  end

  // Memory port follows the granted requester; quiet when nothing is granted.
  always_comb begin
    bus.o_m_en    = w_gnt0 || w_gnt1;
    bus.o_m_we    = 1'b0;
    bus.o_m_addr  = bus.i_r0_addr;
    bus.o_m_wdata = bus.i_r0_wdata;
    if (w_gnt1) begin
      bus.o_m_we    = bus.i_r1_we;
      bus.o_m_addr  = bus.i_r1_addr;
      bus.o_m_wdata = bus.i_r1_wdata;
    end else if (w_gnt0) begin
      bus.o_m_we    = bus.i_r0_we;
    end
  end

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf_mem_arbiter
//
// Directed testbench for bf_mem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// Compile with BF_ARB_RR_EN defined to exercise the round-robin build.
// ---------------------------------------------------------------------------
module tb_bf_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bf_mem_arbiter_if bus();

  bf_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Simple synchronous single-port memory behind the arbiter.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.o_m_en) begin
      if (bus.o_m_we) begin
        mem[bus.o_m_addr] <= bus.o_m_wdata;
      end else begin
        bus.i_m_rdata <= mem[bus.o_m_addr];
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle_inputs();
    bus.i_r0_req = 1'b0; bus.i_r0_we = 1'b0; bus.i_r0_lock = 1'b0;
    bus.i_r0_addr = 8'h00; bus.i_r0_wdata = 8'h00;
    bus.i_r1_req = 1'b0; bus.i_r1_we = 1'b0; bus.i_r1_lock = 1'b0;
    bus.i_r1_addr = 8'h00; bus.i_r1_wdata = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    bus.i_r0_req = 1'b1;
    bus.i_r1_req = 1'b1;
    bus.i_r1_we  = 1'b1;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b0 || bus.o_r1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_gnt: got %b%b want 00", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    checks++;
    if (bus.o_m_en !== 1'b0 || bus.o_m_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mem: en=%b we=%b want 0 0", bus.o_m_en, bus.o_m_we);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.o_r0_rvalid !== 1'b0 || bus.o_r1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_rvalid: got %b%b want 00", bus.o_r0_rvalid, bus.o_r1_rvalid);
    end
    checks++;
    if (bus.o_r0_rdata !== 8'h00 || bus.o_r1_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_rdata: got %h %h want 00 00", bus.o_r0_rdata, bus.o_r1_rdata);
    end
    checks++;
    if (bus.o_lock_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_lock_err: got %b want 0", bus.o_lock_err);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    bus.i_r0_req = 1'b1; bus.i_r0_we = 1'b1;
    bus.i_r0_addr = 8'h10; bus.i_r0_wdata = 8'h2B;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b1 || bus.o_r1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_gnt: got %b%b want 10", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    checks++;
    if (bus.o_m_en !== 1'b1 || bus.o_m_we !== 1'b1 || bus.o_m_addr !== 8'h10 || bus.o_m_wdata !== 8'h2B) begin
      errors++;
      $display("[TB] FAIL wr_mem: en=%b we=%b addr=%h data=%h want 1 1 10 2b",
               bus.o_m_en, bus.o_m_we, bus.o_m_addr, bus.o_m_wdata);
    end
    @(negedge clk);
    idle_inputs();
    bus.i_r1_req = 1'b1; bus.i_r1_addr = 8'h10;
    #1;
    checks++;
    if (bus.o_r1_gnt !== 1'b1 || bus.o_r0_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_gnt: got r0=%b r1=%b want 0 1", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    checks++;
    if (bus.o_r0_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_no_rvalid: got %b want 0", bus.o_r0_rvalid);
    end
    checks++;
    if (bus.o_m_we !== 1'b0 || bus.o_m_addr !== 8'h10) begin
      errors++;
      $display("[TB] FAIL rd_mem: we=%b addr=%h want 0 10", bus.o_m_we, bus.o_m_addr);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.o_r1_rvalid !== 1'b1 || bus.o_r1_rdata !== 8'h2B) begin
      errors++;
      $display("[TB] FAIL rd_data: rvalid=%b rdata=%h want 1 2b", bus.o_r1_rvalid, bus.o_r1_rdata);
    end
    checks++;
    if (bus.o_m_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_m_en: got %b want 0", bus.o_m_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_r1_rvalid !== 1'b0 || bus.o_r1_rdata !== 8'h2B) begin
      errors++;
      $display("[TB] FAIL rd_hold: rvalid=%b rdata=%h want 0 2b", bus.o_r1_rvalid, bus.o_r1_rdata);
    end
  endtask

  task automatic test_simultaneous();
    logic exp0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_r0_req = 1'b1; bus.i_r0_addr = 8'h40;
      bus.i_r1_req = 1'b1; bus.i_r1_addr = 8'h41;
`ifdef BF_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      checks++;
      if (bus.o_r0_gnt !== exp0 || bus.o_r1_gnt !== !exp0) begin
        errors++;
        $display("[TB] FAIL simul_gnt[%0d]: got r0=%b r1=%b want r0=%b r1=%b",
                 i, bus.o_r0_gnt, bus.o_r1_gnt, exp0, !exp0);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock_handoff();
    do_reset();
    @(negedge clk);
    bus.i_r1_req = 1'b1; bus.i_r1_lock = 1'b1; bus.i_r1_addr = 8'h05;
    #1;
    checks++;
    if (bus.o_r1_gnt !== 1'b1 || bus.o_r0_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_first: got r0=%b r1=%b want 0 1", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    @(negedge clk);
    bus.i_r1_req = 1'b0;
    bus.i_r0_req = 1'b1; bus.i_r0_we = 1'b1; bus.i_r0_addr = 8'h20; bus.i_r0_wdata = 8'h55;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b0 || bus.o_r1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_hold: got r0=%b r1=%b want 0 0", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    checks++;
    if (bus.o_r1_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_rvalid: got %b want 1", bus.o_r1_rvalid);
    end
    @(negedge clk);
    bus.i_r1_req = 1'b1; bus.i_r1_we = 1'b1; bus.i_r1_lock = 1'b0; bus.i_r1_wdata = 8'h77;
    #1;
    checks++;
    if (bus.o_r1_gnt !== 1'b1 || bus.o_r0_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_last: got r0=%b r1=%b want 0 1", bus.o_r0_gnt, bus.o_r1_gnt);
    end
    checks++;
    if (bus.o_m_we !== 1'b1 || bus.o_m_addr !== 8'h05 || bus.o_m_wdata !== 8'h77) begin
      errors++;
      $display("[TB] FAIL lock_last_mem: we=%b addr=%h data=%h want 1 05 77",
               bus.o_m_we, bus.o_m_addr, bus.o_m_wdata);
    end
    @(negedge clk);
    bus.i_r1_req = 1'b0; bus.i_r1_we = 1'b0;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b1 || bus.o_m_addr !== 8'h20 || bus.o_r1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handoff: r0_gnt=%b addr=%h r1_rvalid=%b want 1 20 0",
               bus.o_r0_gnt, bus.o_m_addr, bus.o_r1_rvalid);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    @(negedge clk);
    bus.i_r1_req = 1'b1; bus.i_r1_lock = 1'b1; bus.i_r1_addr = 8'h05;
    #1;
    checks++;
    if (bus.o_r1_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_first: got r1_gnt=%b want 1", bus.o_r1_gnt);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      bus.i_r1_req = 1'b0; bus.i_r1_lock = 1'b1;
      bus.i_r0_req = 1'b1; bus.i_r0_addr = 8'h30;
      #1;
      checks++;
      if (bus.o_r0_gnt !== 1'b0 || bus.o_lock_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL to_wait[%0d]: r0_gnt=%b lock_err=%b want 0 0",
                 c, bus.o_r0_gnt, bus.o_lock_err);
      end
    end
    @(negedge clk);
    bus.i_r1_lock = 1'b0;
    #1;
    checks++;
    if (bus.o_lock_err !== 1'b1 || bus.o_r0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_release: lock_err=%b r0_gnt=%b want 1 1", bus.o_lock_err, bus.o_r0_gnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.o_lock_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_pulse: lock_err=%b want 0", bus.o_lock_err);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    bus.i_r0_req = 1'b1; bus.i_r0_addr = 8'h10;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_gnt: got %b want 1", bus.o_r0_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.i_r1_req = 1'b1; bus.i_r1_lock = 1'b1; bus.i_r1_addr = 8'h11;
    #1;
    checks++;
    if (bus.o_r0_rvalid !== 1'b0 || bus.o_r0_gnt !== 1'b0 || bus.o_r1_gnt !== 1'b0 || bus.o_m_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rst: rvalid=%b gnt=%b%b m_en=%b want 0 00 0",
               bus.o_r0_rvalid, bus.o_r0_gnt, bus.o_r1_gnt, bus.o_m_en);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_r0_gnt !== 1'b1 || bus.o_r1_gnt !== 1'b0 || bus.o_r0_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_after: gnt=%b%b rvalid=%b want 10 0",
               bus.o_r0_gnt, bus.o_r1_gnt, bus.o_r0_rvalid);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    $display("[TB] bf_mem_arbiter directed test start");
    test_reset();
    test_write_read();
    test_simultaneous();
    test_lock_handoff();
    test_lock_timeout();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
